// File: rtl/reg4_write_arbiter_if.sv
// Handshake bundle between the control sources (master) and the 4-bit write arbiter (slave).
// The master side drives requests and data and observes the shared register and status.
interface reg4_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
);
   logic                   arb_enable;
   logic [NUM_REQ-1:0]     req;
   logic [4*NUM_REQ-1:0]   req_data;
   logic [NUM_REQ-1:0]     ack;
   logic [3:0]             data_out;
   logic                   wr_strobe;
   logic [IDX_W-1:0]       grant_id;
   logic                   busy;
   logic [15:0]            write_count;

   modport master (
      output arb_enable, req, req_data,
      input  ack, data_out, wr_strobe, grant_id, busy, write_count
   );

   modport slave (
      input  arb_enable, req, req_data,
      output ack, data_out, wr_strobe, grant_id, busy, write_count
   );
endinterface

// File: rtl/reg4_write_arbiter.sv
// Round-robin arbiter sharing one 4-bit register among NUM_REQ requesters,
// with a programmable cooldown between writes and a wrapping write counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting; arbitrates from rr_ptr when enabled and any req set
// GRANT   | winner latched; writes if its req is still high, else aborts
// WRITE   | ack/wr_strobe pulse, data_out already holds the new value
// COOL    | COOLDOWN idle cycles before the next arbitration
module reg4_write_arbiter #(
   parameter  int NUM_REQ  = 4,
   parameter  int COOLDOWN = 1,
   localparam int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                    clock,
   input  logic                    reset,
   reg4_write_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WRITE = 2'd2,
      ST_COOL  = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     gid, gid_nxt;
   logic [IDX_W-1:0]     rr_ptr, rr_nxt;
   logic [IDX_W-1:0]     pick;
   logic                 pick_valid;
   logic [3:0]           data_q, data_nxt;
   logic [3:0]           cool_cnt, cool_nxt;
   logic [NUM_REQ-1:0]   ack_q, ack_nxt;
   logic                 strobe_q, strobe_nxt;
   logic [15:0]          wr_count, count_nxt;

   // Modulo-NUM_REQ add that also works when NUM_REQ is not a power of two.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   // Scanning downward lets the lowest offset from rr_ptr overwrite earlier hits.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[wrap_add(rr_ptr, k)]) begin
            pick       = wrap_add(rr_ptr, k);
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      gid_nxt    = gid;
      rr_nxt     = rr_ptr;
      data_nxt   = data_q;
      cool_nxt   = cool_cnt;
      ack_nxt    = '0;
      strobe_nxt = 1'b0;
      count_nxt  = wr_count;
      case (state)
         ST_IDLE: begin
            if (bus.arb_enable && pick_valid) begin
               gid_nxt   = pick;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (bus.req[gid]) begin
               data_nxt     = bus.req_data[4*int'(gid) +: 4];
               ack_nxt[gid] = 1'b1;
               strobe_nxt   = 1'b1;
               count_nxt    = wr_count + 16'd1;
               rr_nxt       = wrap_add(gid, 1);
               state_nxt    = ST_WRITE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (COOLDOWN > 0) begin
               cool_nxt  = 4'(COOLDOWN);
               state_nxt = ST_COOL;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_COOL: begin
            cool_nxt = cool_cnt - 4'd1;
            if (cool_cnt <= 4'd1) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         gid      <= '0;
         rr_ptr   <= '0;
         data_q   <= '0;
         cool_cnt <= '0;
         ack_q    <= '0;
         strobe_q <= 1'b0;
         wr_count <= '0;
      end else begin
         state    <= state_nxt;
         gid      <= gid_nxt;
         rr_ptr   <= rr_nxt;
         data_q   <= data_nxt;
         cool_cnt <= cool_nxt;
         ack_q    <= ack_nxt;
         strobe_q <= strobe_nxt;
         wr_count <= count_nxt;
      end
   end

   assign bus.ack         = ack_q;
   assign bus.data_out    = data_q;
   assign bus.wr_strobe   = strobe_q;
   assign bus.grant_id    = gid;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.write_count = wr_count;

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Bench for reg4_write_arbiter: vector table, directed corner sequences and a
// randomized run against a timestamp-based reference model.
module tb_reg4_write_arbiter;
   localparam int N  = 4;
   localparam int C  = 1;
   localparam int IW = 2;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   reg4_write_arbiter_if #(.NUM_REQ(N)) bus ();
   reg4_write_arbiter #(.NUM_REQ(N), .COOLDOWN(C)) dut (.clock(clock), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   typedef struct {
      logic        en;
      logic [3:0]  rq;
      logic [15:0] dat;
      logic [3:0]  exp_ack;
      logic [3:0]  exp_data;
   } vec_t;
   vec_t vecs[7];

   // Reference model: tracks the edge index from which the block is idle again
   // instead of an explicit state machine.
   int          n_edge;
   int          m_rr, m_gid, m_busy_till;
   bit          m_pend;
   logic [3:0]  m_data;
   logic [15:0] m_count;
   logic [3:0]  e_ack;
   bit          e_strobe, e_busy;

   task automatic model_edge(input bit rst, input bit en, input logic [3:0] rq, input logic [15:0] dat);
      n_edge++;
      e_ack    = '0;
      e_strobe = 1'b0;
      if (rst) begin
         m_rr = 0; m_gid = 0; m_data = '0; m_count = '0; m_pend = 1'b0;
         m_busy_till = n_edge;
      end else if (m_pend) begin
         m_pend = 1'b0;
         if (rq[m_gid]) begin
            m_data        = dat[4*m_gid +: 4];
            e_ack[m_gid]  = 1'b1;
            e_strobe      = 1'b1;
            m_count       = m_count + 16'd1;
            m_rr          = (m_gid + 1) % N;
            m_busy_till   = n_edge + 1 + C;
         end else begin
            m_busy_till = n_edge;
         end
      end else if (n_edge - 1 >= m_busy_till && en && rq != 0) begin
         bit found;
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!found && rq[(m_rr + k) % N]) begin
               m_gid = (m_rr + k) % N;
               found = 1'b1;
            end
         end
         m_pend = 1'b1;
      end
      e_busy = m_pend || (n_edge < m_busy_till);
   endtask

   initial begin
      int ack_edge[$];
      int ack_idx[$];
      int ack_dat[$];
      int bad;
      logic [3:0]  r_req;
      logic [15:0] r_dat;
      bit          r_en, r_rst;

      reset        = 1'b1;
      bus.arb_enable = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_data", 32'(bus.data_out), 0);
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_count", 32'(bus.write_count), 0);
      chk("rst_gid", 32'(bus.grant_id), 0);
      chk("rst_strobe", 32'(bus.wr_strobe), 0);

      // Single-write vectors, each from a fresh reset (rr_ptr=0)
      vecs[0] = '{1'b1, 4'b0100, 16'h0B00, 4'b0100, 4'hB};
      vecs[1] = '{1'b1, 4'b1010, 16'h7060, 4'b0010, 4'h6};
      vecs[2] = '{1'b1, 4'b1000, 16'hD000, 4'b1000, 4'hD};
      vecs[3] = '{1'b1, 4'b1111, 16'h4321, 4'b0001, 4'h1};
      vecs[4] = '{1'b0, 4'b0100, 16'h0F00, 4'b0000, 4'h0};
      vecs[5] = '{1'b1, 4'b0000, 16'hFFFF, 4'b0000, 4'h0};
      vecs[6] = '{1'b1, 4'b0110, 16'h0950, 4'b0010, 4'h5};
      foreach (vecs[v]) begin
         do_reset();
         bus.arb_enable = vecs[v].en;
         bus.req        = vecs[v].rq;
         bus.req_data   = vecs[v].dat;
         tick();
         tick();
         chk($sformatf("vec%0d_ack", v), 32'(bus.ack), 32'(vecs[v].exp_ack));
         chk($sformatf("vec%0d_strobe", v), 32'(bus.wr_strobe), 32'(vecs[v].exp_ack != 0));
         chk($sformatf("vec%0d_data", v), 32'(bus.data_out), 32'(vecs[v].exp_data));
         chk($sformatf("vec%0d_count", v), 32'(bus.write_count), 32'(vecs[v].exp_ack != 0));
         bus.req = '0;
         repeat (3) tick();
      end

      // Single write timing with cooldown 1
      bus.arb_enable = 1'b1;
      do_reset();
      bus.req = 4'b0010; bus.req_data = 16'h00A0;
      tick();
      chk("single_grant_busy", 32'(bus.busy), 1);
      chk("single_grant_ack", 32'(bus.ack), 0);
      tick();
      chk("single_ack", 32'(bus.ack), 32'b0010);
      chk("single_strobe", 32'(bus.wr_strobe), 1);
      chk("single_data", 32'(bus.data_out), 32'hA);
      chk("single_count", 32'(bus.write_count), 1);
      chk("single_gid", 32'(bus.grant_id), 1);
      bus.req = '0;
      tick();
      chk("single_cool_busy", 32'(bus.busy), 1);
      chk("single_cool_ack", 32'(bus.ack), 0);
      tick();
      chk("single_idle_busy", 32'(bus.busy), 0);
      chk("single_hold_data", 32'(bus.data_out), 32'hA);

      // Full contention: rotation 0,1,2,3,0 spaced 3+C cycles
      do_reset();
      bus.req = 4'b1111; bus.req_data = 16'hC953;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (bus.ack[i]) begin
               ack_edge.push_back(cyc);
               ack_idx.push_back(i);
               ack_dat.push_back(int'(bus.data_out));
            end
         end
      end
      bus.req = '0;
      chk("cont_ack_count_ge5", 32'(ack_idx.size() >= 5), 1);
      for (int j = 0; j < 5 && j < ack_idx.size(); j++) begin
         logic [15:0] dv;
         dv = 16'hC953;
         chk($sformatf("cont_order%0d", j), 32'(ack_idx[j]), 32'(j % N));
         chk($sformatf("cont_data%0d", j), 32'(ack_dat[j]), 32'(dv[4*(j%N) +: 4]));
         if (j > 0) chk($sformatf("cont_space%0d", j), 32'(ack_edge[j] - ack_edge[j-1]), 32'(3 + C));
      end
      repeat (4) tick();

      // Withdrawal during GRANT leaves rr_ptr at 0
      do_reset();
      bus.req = 4'b1000; bus.req_data = 16'h7000;
      tick();
      bus.req = 4'b0000;
      tick();
      chk("wd_ack", 32'(bus.ack), 0);
      chk("wd_data", 32'(bus.data_out), 0);
      chk("wd_count", 32'(bus.write_count), 0);
      chk("wd_busy", 32'(bus.busy), 0);
      bus.req = 4'b1001; bus.req_data = 16'h7002;
      tick();
      chk("wd_gid_after", 32'(bus.grant_id), 0);
      tick();
      chk("wd_next_ack", 32'(bus.ack), 32'b0001);
      chk("wd_next_data", 32'(bus.data_out), 2);
      bus.req = '0;
      repeat (3) tick();

      // Enable gating
      do_reset();
      bus.arb_enable = 1'b0;
      bus.req = 4'b0100; bus.req_data = 16'h0600;
      bad = 0;
      repeat (10) begin
         tick();
         if (bus.ack != 0 || bus.busy) bad++;
      end
      chk("gate_idle_cycles_bad", 32'(bad), 0);
      bus.arb_enable = 1'b1;
      tick();
      tick();
      chk("gate_ack2", 32'(bus.ack), 32'b0100);
      bus.req = '0;
      repeat (3) tick();
      chk("gate_idle_again", 32'(bus.busy), 0);
      bus.req = 4'b0001; bus.req_data = 16'h0009;
      tick();
      bus.arb_enable = 1'b0;
      tick();
      chk("gate_drop_ack", 32'(bus.ack), 32'b0001);
      chk("gate_drop_data", 32'(bus.data_out), 9);
      bad = 0;
      repeat (8) begin
         tick();
         if (bus.ack != 0) bad++;
      end
      chk("gate_disabled_no_ack", 32'(bad), 0);
      chk("gate_disabled_busy", 32'(bus.busy), 0);
      chk("gate_count", 32'(bus.write_count), 2);

      // Reset during GRANT aborts the write; a lone req[2] is granted first afterwards
      bus.arb_enable = 1'b1;
      bus.req = 4'b0100; bus.req_data = 16'h0F00;
      tick();
      chk("rg_in_grant", 32'(bus.busy), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rg_ack", 32'(bus.ack), 0);
      chk("rg_data", 32'(bus.data_out), 0);
      chk("rg_count", 32'(bus.write_count), 0);
      chk("rg_busy", 32'(bus.busy), 0);
      tick();
      tick();
      chk("rg_next_ack", 32'(bus.ack), 32'b0100);
      chk("rg_next_data", 32'(bus.data_out), 32'hF);
      bus.req = '0;
      repeat (3) tick();

      // Write counter wrap from 0xFFFF
      force dut.wr_count = 16'hFFFF;
      #2;
      release dut.wr_count;
      #1;
      chk("wrap_preload", 32'(bus.write_count), 32'hFFFF);
      bus.req = 4'b0001; bus.req_data = 16'h0003;
      tick();
      tick();
      chk("wrap_ack", 32'(bus.ack), 32'b0001);
      chk("wrap_count", 32'(bus.write_count), 0);
      bus.req = '0;
      repeat (3) tick();

      // Randomized run against the reference model
      n_edge = 0;
      r_req = '0; r_dat = '0; r_en = 1'b1; r_rst = 1'b1;
      e_ack = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (e_ack[i]) begin
               if ($urandom_range(0, 1) == 0) r_req[i] = 1'b0;
               else r_dat[4*i +: 4] = 4'($urandom_range(0, 15));
            end else if (!r_req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  r_req[i] = 1'b1;
                  r_dat[4*i +: 4] = 4'($urandom_range(0, 15));
               end
            end else if ($urandom_range(0, 31) == 0) begin
               r_req[i] = 1'b0;
            end
         end
         r_en  = ($urandom_range(0, 15) != 0);
         if (cyc != 0) r_rst = ($urandom_range(0, 499) == 0);
         reset = r_rst;
         bus.arb_enable = r_en;
         bus.req = r_req;
         bus.req_data = r_dat;
         tick();
         model_edge(r_rst, r_en, r_req, r_dat);
         chk("rnd_ack", 32'(bus.ack), 32'(e_ack));
         chk("rnd_strobe", 32'(bus.wr_strobe), 32'(e_strobe));
         chk("rnd_data", 32'(bus.data_out), 32'(m_data));
         chk("rnd_gid", 32'(bus.grant_id), 32'(m_gid));
         chk("rnd_busy", 32'(bus.busy), 32'(e_busy));
         chk("rnd_count", 32'(bus.write_count), 32'(m_count));
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg4_write_arbiter.md
Name: reg4_write_arbiter

Overview:
Round-robin write arbiter that shares one 4-bit storage register among NUM_REQ requesters using a req/ack handshake. Each requester presents 4-bit data and holds req until ack. The block grants one requester at a time, loads its data into the shared register, and enforces a programmable cooldown between writes. It sits between the control sources and the 4-bit register datapath, and provides a write counter for status readback.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
COOLDOWN, 1, idle cycles after each write before the next grant (0..15).
IDX_W, $clog2(NUM_REQ), width of the grant index (derived; not overridden).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
arb_enable  input  1  when 0, no new grant is issued from IDLE; any write in progress completes.
req  input  NUM_REQ  per-requester write request; level, held until ack.
req_data  input  4*NUM_REQ  flattened data; requester i uses bits [4i+3:4i].
ack  output  NUM_REQ  one-hot, one-cycle pulse to the serviced requester.
data_out  output  4  shared register contents.
wr_strobe  output  1  one-cycle pulse, coincident with the first cycle data_out shows new data.
grant_id  output  IDX_W  index of the current or last grantee.
busy  output  1  high in GRANT, WRITE or COOL.
write_count  output  16  count of completed writes; wraps 0xFFFF->0.

Behaviour:
- Reset: when reset=1 at a clock edge, all registers clear on that edge.
  - Reset values: state=IDLE, data_out=0, ack=0, wr_strobe=0, grant_id=0, busy=0, write_count=0, rr_ptr=0, cooldown counter=0.
  - Reset asserted mid-operation aborts the transfer: no ack, no register update.
- States: IDLE, GRANT, WRITE, COOL.
- IDLE:
  - If arb_enable=1 and req!=0, pick the first requester with req=1, scanning from rr_ptr upward modulo NUM_REQ.
  - Register the winner in grant_id; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle, busy=1):
  - If req[grant_id]=1 at the end of the cycle: data_out <= req_data[grant_id], ack[grant_id] <= 1, wr_strobe <= 1, write_count++, rr_ptr <= (grant_id+1) mod NUM_REQ. Go to WRITE.
  - If req[grant_id]=0 (requester withdrew): no write, no ack, rr_ptr unchanged. Go to IDLE.
- WRITE (1 cycle):
  - ack and wr_strobe are high in this cycle only; data_out already holds the new value.
  - Go to COOL if COOLDOWN>0 (load counter=COOLDOWN), else go to IDLE.
- COOL:
  - Decrement the counter each cycle; go to IDLE in the cycle the counter reads 1.
  - Requests are ignored during COOL.
- Latency: req rising, sampled in IDLE at edge t -> ack and new data_out visible in cycle t+2.
  - Minimum spacing between successive acks is 3+COOLDOWN cycles.
- Requester protocol:
  - req and data must be stable from assertion until the ack cycle.
  - Requester drops req in the cycle after ack, or keeps it high to request again.
  - A req still high during the ack cycle is treated as a new request at the next IDLE.
- Fairness: the just-serviced requester has lowest priority next time.
  - With all requesters active, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Simultaneous requests: only one winner per arbitration; losers wait, keeping req asserted.
- arb_enable falling while in GRANT/WRITE/COOL: the sequence finishes normally, then the block stays in IDLE.
- data_out holds its value indefinitely between writes.
- At most one ack bit is ever set.
- write_count wraps without a flag.

Test Plan:
- Reset: apply random activity, then reset=1 for 1 cycle -> data_out=0, ack=0, busy=0, write_count=0 on the next cycle; a subsequent single req[2] is granted first, since the rr_ptr scan from 0 finds 2.
- Single write, COOLDOWN=1: req[1]=1, req_data[1]=4'hA sampled at edge t -> ack=4'b0010 and wr_strobe in cycle t+2, data_out=4'hA, write_count=1, busy low at t+4.
- Full contention: req=4'b1111 held, distinct data 4'h3,4'h5,4'h9,4'hC -> ack order 0,1,2,3,0, acks spaced 4 cycles apart, data_out follows each grantee.
- Withdrawal: req[3] asserted 1 cycle, then dropped during GRANT -> no ack, data_out unchanged, write_count unchanged, return to IDLE, rr_ptr unchanged (next req[0],req[3] both high -> 0 wins if rr_ptr=0).
- Enable gating: arb_enable=0 with req=4'b0100 for 10 cycles -> no ack, busy=0; raise arb_enable -> ack[2] 2 cycles later. Drop enable during GRANT -> that write still completes.
- Counter wrap and reset mid-transfer: preload write_count to 0xFFFF via 65535 writes (or a force), one more write -> 0x0000. Separately, reset asserted during GRANT -> no ack, data_out=0.
